// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode encodings and pointer/width helpers,
// intended for reuse by the single- and multi-channel FIFOs.
package fifo_pkg;

    typedef enum int {
        RD_FWFT = 0,
        RD_REG  = 1
    } read_mode_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One extra wrap bit lets a full FIFO be told apart from an empty one.
    function automatic int ptr_width(input int cells);
        return clog2(cells) + 1;
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Streaming FIFO bus: write side, read side, flush and status.
// The master modport is the user of the FIFO, the slave modport is the FIFO itself.
interface fifo_param_if
    import fifo_pkg::*;
#(
    parameter int depth = 64,
    parameter int size  = 8
);
    localparam int CNT_W = ptr_width(depth);

    logic             clear;
    logic [size-1:0]  datain;
    logic             enw;
    logic             full;
    logic             almost_full;
    logic             enr;
    logic [size-1:0]  dataout;
    logic             dout_valid;
    logic             empty;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, datain, enw, enr,
        input  full, almost_full, dataout, dout_valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, datain, enw, enr,
        output full, almost_full, dataout, dout_valid, empty, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_param_ram.sv
// Simple dual-port storage for the FIFO: one write port, one read port that is
// asynchronous (fall-through) or registered, selected by READ_MODE. No reset.
module fifo_param_ram
    import fifo_pkg::*;
#(
    parameter int depth     = 64,
    parameter int size      = 8,
    parameter int READ_MODE = 0,
    parameter int ADDR_W    = clog2(depth)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [size-1:0]   i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [size-1:0]   o_rdata
);

    logic [size-1:0] r_mem [depth];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (READ_MODE == int'(RD_REG)) begin : g_syncRead
            logic [size-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (i_re) begin
                    r_rdata <= r_mem[i_raddr];
                end
            end

            assign o_rdata = r_rdata;
        end else begin : g_asyncRead
            logic w_unusedRe;

            assign w_unusedRe = i_re;
            assign o_rdata    = r_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/fifo_param.sv
// Parametrised streaming FIFO with wrap-bit pointers, occupancy, programmable
// almost-full/almost-empty, sticky overflow/underflow, flush and two read modes.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int depth     = 64,
    parameter int size      = 8,
    parameter int AF_LEVEL  = 56,
    parameter int AE_LEVEL  = 8,
    parameter int READ_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    fifo_param_if.slave  bus
);

    localparam int ADDR_W = clog2(depth);
    localparam int PTR_W  = ptr_width(depth);

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_doutValid;
    logic             r_popSeen;

    logic [PTR_W-1:0] w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_rdAcc;
    logic             w_wrAcc;
    logic [size-1:0]  w_ramData;

    assign w_count = r_wrPtr - r_rdPtr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == PTR_W'(depth));

    // A full FIFO still takes a write when a pop frees the head cell in the same cycle.
    assign w_rdAcc = bus.enr && !w_empty;
    assign w_wrAcc = bus.enw && (!w_full || bus.enr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_doutValid <= 1'b0;
            r_popSeen   <= 1'b0;
        end else if (bus.clear) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_doutValid <= 1'b0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdAcc) begin
                r_rdPtr   <= r_rdPtr + 1'b1;
                r_popSeen <= 1'b1;
            end
            if (bus.enw && !w_wrAcc) begin
                r_overflow <= 1'b1;
            end
            if (bus.enr && w_empty) begin
                r_underflow <= 1'b1;
            end
            r_doutValid <= (READ_MODE == int'(RD_REG)) && w_rdAcc;
        end
    end

    fifo_param_ram #(
        .depth     (depth),
        .size      (size),
        .READ_MODE (READ_MODE),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wrAcc && !bus.clear),
        .i_waddr (r_wrPtr[ADDR_W-1:0]),
        .i_wdata (bus.datain),
        .i_re    (w_rdAcc && !bus.clear),
        .i_raddr (r_rdPtr[ADDR_W-1:0]),
        .o_rdata (w_ramData)
    );

    // The resetless read register is masked to zero until the first pop after reset.
    assign bus.dataout      = ((READ_MODE == int'(RD_REG)) && !r_popSeen) ? '0 : w_ramData;
    assign bus.dout_valid   = r_doutValid;
    assign bus.count        = w_count;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (w_count >= PTR_W'(AF_LEVEL));
    assign bus.almost_empty = (w_count <= PTR_W'(AE_LEVEL));
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: fall-through instance (depth 4, AF 3, AE 1)
// and registered-read instance, checked against a queue model.
module tb_fifo_param;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] qA[$];
    logic [7:0] qB[$];
    logic       ovfA = 1'b0;
    logic       unfA = 1'b0;

    fifo_param_if #(.depth(4), .size(8)) ifA ();
    fifo_param_if #(.depth(4), .size(8)) ifB ();

    fifo_param #(
        .depth(4), .size(8), .AF_LEVEL(3), .AE_LEVEL(1), .READ_MODE(0)
    ) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    fifo_param #(
        .depth(4), .size(8), .AF_LEVEL(3), .AE_LEVEL(1), .READ_MODE(1)
    ) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkStatusA(input string tag);
        checkOutput({tag, ":count"},  32'(ifA.count),        32'(qA.size()));
        checkOutput({tag, ":empty"},  32'(ifA.empty),        32'(qA.size() == 0));
        checkOutput({tag, ":full"},   32'(ifA.full),         32'(qA.size() == 4));
        checkOutput({tag, ":af"},     32'(ifA.almost_full),  32'(qA.size() >= 3));
        checkOutput({tag, ":ae"},     32'(ifA.almost_empty), 32'(qA.size() <= 1));
        checkOutput({tag, ":ovf"},    32'(ifA.overflow),     32'(ovfA));
        checkOutput({tag, ":unf"},    32'(ifA.underflow),    32'(unfA));
        checkOutput({tag, ":dvalid"}, 32'(ifA.dout_valid),   32'(0));
    endtask

    // One clock of stimulus on the fall-through instance; the model decides acceptance.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c, input string tag);
        logic wasEmpty;
        logic rdAcc;
        logic wrAcc;
        @(negedge clk);
        ifA.enw    = w;
        ifA.datain = d;
        ifA.enr    = r;
        ifA.clear  = c;
        #1;
        if (c) begin
            qA.delete();
            ovfA = 1'b0;
            unfA = 1'b0;
        end else begin
            wasEmpty = (qA.size() == 0);
            rdAcc    = r && !wasEmpty;
            wrAcc    = w && ((qA.size() != 4) || r);
            if (rdAcc) begin
                checkOutput({tag, ":data"}, 32'(ifA.dataout), 32'(qA.pop_front()));
            end
            if (w && !wrAcc) ovfA = 1'b1;
            if (r && wasEmpty) unfA = 1'b1;
            if (wrAcc) qA.push_back(d);
        end
        @(posedge clk);
        #1;
        ifA.enw   = 1'b0;
        ifA.enr   = 1'b0;
        ifA.clear = 1'b0;
        checkStatusA(tag);
    endtask

    task automatic stepB(input logic w, input logic [7:0] d, input logic r);
        @(negedge clk);
        ifB.enw    = w;
        ifB.datain = d;
        ifB.enr    = r;
        if (w) qB.push_back(d);
        @(posedge clk);
        #1;
        ifB.enw = 1'b0;
        ifB.enr = 1'b0;
    endtask

    initial begin
        logic [7:0] lastB;
        rst = 1'b0;
        ifA.enw = 1'b0; ifA.enr = 1'b0; ifA.clear = 1'b0; ifA.datain = '0;
        ifB.enw = 1'b0; ifB.enr = 1'b0; ifB.clear = 1'b0; ifB.datain = '0;
        #12;
        checkStatusA("reset");
        checkOutput("reset:B_dvalid", 32'(ifB.dout_valid), 32'(0));
        checkOutput("reset:B_data",   32'(ifB.dataout),    32'(0));
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, "fill1");
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, "fill2");
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, "fill3");
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, "fill4");
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, "overflow");
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, "passthru");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain1");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain3");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain4");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "underflow");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "clear1");
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, "wrEmptyRd");
        applyStimulus(1'b1, 8'h88, 1'b0, 1'b0, "count2");
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, "count3");
        applyStimulus(1'b1, 8'hAB, 1'b1, 1'b1, "clear2");

        // Registered-read instance: data and dout_valid follow each pop by one cycle.
        stepB(1'b1, 8'hA5, 1'b0);
        stepB(1'b1, 8'h3C, 1'b0);
        checkOutput("B:count2", 32'(ifB.count),      32'(2));
        checkOutput("B:idle",   32'(ifB.dout_valid), 32'(0));
        stepB(1'b0, 8'h00, 1'b1);
        checkOutput("B:pop1_valid", 32'(ifB.dout_valid), 32'(1));
        lastB = qB.pop_front();
        checkOutput("B:pop1_data",  32'(ifB.dataout),    32'(lastB));
        stepB(1'b0, 8'h00, 1'b1);
        checkOutput("B:pop2_valid", 32'(ifB.dout_valid), 32'(1));
        lastB = qB.pop_front();
        checkOutput("B:pop2_data",  32'(ifB.dataout),    32'(lastB));
        stepB(1'b0, 8'h00, 1'b0);
        checkOutput("B:after_valid", 32'(ifB.dout_valid), 32'(0));
        checkOutput("B:hold_data",   32'(ifB.dataout),    32'(lastB));
        checkOutput("B:empty",       32'(ifB.empty),      32'(1));
        checkOutput("B:unf",         32'(ifB.underflow),  32'(0));

        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, "refill1");
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0, "refill2");
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, "refill3");

        // Asynchronous reset arrives between edges while a write is being presented.
        @(negedge clk);
        ifA.enw    = 1'b1;
        ifA.datain = 8'hEE;
        #2;
        rst = 1'b0;
        #1;
        qA.delete();
        ovfA = 1'b0;
        unfA = 1'b0;
        checkStatusA("midReset");
        checkOutput("midReset:B_data", 32'(ifB.dataout), 32'(0));
        @(negedge clk);
        ifA.enw = 1'b0;
        rst     = 1'b1;

        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, "postReset_wr");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "postReset_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
